nway_wb_cache: RTL and testbench
================================

Name: nway_wb_cache

Overview:
Parametrised N-way set-associative, write-back, write-allocate data cache with multi-word lines and true-LRU replacement. It is the next-generation replacement for the 2-way, single-word, write-through-less data cache in the pipelined core. It sits between the MEM stage (CPU port) and data memory (word-burst memory port). On any miss it stalls the pipeline and runs a writeback/refill state machine.

Parameters:
DATA_WIDTH, 32, CPU word and memory word width
ADDR_WIDTH, 32, byte address width
NUM_SETS, 4, sets (power of 2, >=2)
NUM_WAYS, 2, ways per set (power of 2, >=2)
WORDS_PER_LINE, 4, words per line (power of 2, >=1)

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
cpu_re  in  1  load request
cpu_we  in  1  store request (full word)
cpu_addr  in  ADDR_WIDTH  byte address, word aligned
cpu_wdata  in  DATA_WIDTH  store data
cpu_rdata  out  DATA_WIDTH  load data, valid when cpu_re && !stall
stall  out  1  high while the request cannot complete this cycle
mem_req  out  1  memory word transfer request
mem_we  out  1  1 = writeback word, 0 = refill read
mem_addr  out  ADDR_WIDTH  word-aligned byte address of transfer
mem_wdata  out  DATA_WIDTH  writeback data
mem_rdata  in  DATA_WIDTH  refill data
mem_ready  in  1  transfer completes in the cycle mem_req && mem_ready

Behaviour:
- Address split, LSB first: 2 byte bits (ignored); WOFF = log2(WORDS_PER_LINE) bits; IDX = log2(NUM_SETS) bits; remaining bits are TAG.
- Reset: clears all valid and dirty bits and sets LRU age of way w to w in every set. FSM goes to IDLE. Outputs: stall=0, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, cpu_rdata=0. Data and tag arrays are not reset.
- Hit: valid && tag match in any way. Priority goes to the lowest way index, although duplicates must never occur.
- Load hit: cpu_rdata is combinational in the same cycle and stall=0. When there is no hit, cpu_rdata=0.
- Store hit: the word is written at the clk edge, dirty is set, and stall=0.
- LRU update on every hit in IDLE: the hit way's age goes to 0. Ways younger than its old age increment by 1; others are unchanged. Ages stay a permutation of 0..NUM_WAYS-1.
- Victim selection: lowest-index invalid way, else the way with age NUM_WAYS-1. It is latched on miss entry together with the miss address.
- FSM:
  - IDLE: on (cpu_re||cpu_we) && !hit, stall goes high combinationally. If the victim is valid && dirty, go to WB; else go to REFILL. A word counter is cleared.
  - WB: mem_req=1, mem_we=1. mem_addr = {victim tag, IDX, counter, 2'b00}. mem_wdata = victim word[counter]. On mem_ready the counter increments. At the last word, clear the counter and go to REFILL.
  - REFILL: mem_req=1, mem_we=0. mem_addr = {miss tag, IDX, counter, 2'b00}. On mem_ready, write mem_rdata into victim word[counter]. At the last word, set valid=1, dirty=0, tag=miss tag, and go to IDLE.
  - Return to IDLE: the request is re-evaluated. It now hits, so the store/load completes with normal hit behaviour including the LRU update. The total miss penalty is WB beats + WORDS_PER_LINE beats + 1 cycle.
- stall=1 throughout WB and REFILL, and in IDLE on a miss.
- CPU inputs must be held stable while stall=1. Behaviour is undefined otherwise.
- cpu_re && cpu_we together is treated as a store.
- mem_ready low stalls the FSM indefinitely with mem_* held stable.
- rst mid-WB/REFILL: the FSM aborts to IDLE and all lines are invalidated. The next cycle has mem_req=0 and no memory write is completed.

Decomposition:
- Package nway_cache_pkg holds:
  - the FSM state enum (IDLE, WB, REFILL);
  - address-field width localparam helpers (WOFF_W, IDX_W, TAG_W as functions of the parameters);
  - the 2-bit byte-offset constant.
- One sub-module, cache_lru_set, is natural. It holds the NUM_WAYS age registers for a single set, with inputs touch_en/touch_way and output victim_way. The top instantiates it NUM_SETS times via generate.

Test Plan:
- Default params. Reset, then load 0x0000_0040 with memory returning word i = 0xA0+i. The bench must see stall for 4 REFILL beats plus 1, mem_addr 0x40, 0x44, 0x48, 0x4C, then cpu_rdata=0xA0 with stall=0.
- After the above, load 0x0000_0048: same-cycle hit, cpu_rdata=0xA2, no mem_req.
- Store 0xDEAD_BEEF to 0x40 (hit, dirty). Fill way 1 of set 0 via 0x0000_0140, then load 0x0000_0240 (set 0, way 0 is LRU). The bench must see 4 WB beats at 0x40..0x4C with the first mem_wdata=0xDEAD_BEEF, then a refill at 0x240..0x24C.
- Clean eviction: same sequence without the store. There must be no mem_we=1 beat; only a refill is issued.
- LRU ordering with NUM_WAYS=4: access tags T0, T1, T2, T3, then T0 again, then miss T4 in the same set. The victim must be the T1 way.
- mem_ready held low 5 cycles during REFILL: mem_addr stays stable and stall stays 1. Asserting rst mid-REFILL gives mem_req=0 next cycle, and a subsequent load to the same address misses.

Source files
------------

// File: rtl/nway_cache_pkg.sv
// Shared types and address-field helpers for the N-way write-back data cache.
// The width helpers take the cache parameters because a package cannot see module parameters.
package nway_cache_pkg;

  localparam int         BYTE_OFF_W = 2;
  localparam logic [1:0] BYTE_OFF   = 2'b00;

  typedef enum logic [1:0] {
    IDLE,
    WB,
    REFILL
  } state_t;

  function automatic int woff_w(input int words_per_line);
    return $clog2(words_per_line);
  endfunction

  function automatic int idx_w(input int num_sets);
    return $clog2(num_sets);
  endfunction

  function automatic int tag_w(input int addr_w, input int words_per_line, input int num_sets);
    return addr_w - BYTE_OFF_W - woff_w(words_per_line) - idx_w(num_sets);
  endfunction

endpackage

// File: rtl/cache_lru_set.sv
// True-LRU age registers for one set: age 0 is most recent, NUM_WAYS-1 is the victim.
// Ages always remain a permutation of 0..NUM_WAYS-1.
module cache_lru_set #(
  parameter int NUM_WAYS = 2
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        touch_en,
  input  logic [$clog2(NUM_WAYS)-1:0] touch_way,
  output logic [$clog2(NUM_WAYS)-1:0] victim_way
);

  localparam int WAY_W = $clog2(NUM_WAYS);

  logic [WAY_W-1:0] r_age [NUM_WAYS];
  logic [WAY_W-1:0] w_victim;

  // NOTE: state is updated with non-blocking assignments so every age compares against the pre-touch value.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int w = 0; w < NUM_WAYS; w++) r_age[w] <= WAY_W'(w);
    end else if (touch_en) begin
      for (int w = 0; w < NUM_WAYS; w++) begin
        if (WAY_W'(w) == touch_way)          r_age[w] <= '0;
        else if (r_age[w] < r_age[touch_way]) r_age[w] <= r_age[w] + 1'b1;
      end
    end
  end

  // NOTE: default assignment first keeps this combinational block latch-free.
  always_comb begin
    w_victim = '0;
    for (int w = 0; w < NUM_WAYS; w++) begin
      if (r_age[w] == WAY_W'(NUM_WAYS - 1)) w_victim = WAY_W'(w);
    end
  end

  assign victim_way = w_victim;

endmodule

// File: rtl/nway_wb_cache.sv
// N-way set-associative write-back, write-allocate data cache with multi-word lines.
// Misses stall the core while a single FSM writes back the dirty victim and refills the line.
module nway_wb_cache
  import nway_cache_pkg::*;
#(
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_WIDTH     = 32,
  parameter int NUM_SETS       = 4,
  parameter int NUM_WAYS       = 2,
  parameter int WORDS_PER_LINE = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cpu_re,
  input  logic                  cpu_we,
  input  logic [ADDR_WIDTH-1:0] cpu_addr,
  input  logic [DATA_WIDTH-1:0] cpu_wdata,
  output logic [DATA_WIDTH-1:0] cpu_rdata,
  output logic                  stall,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  input  logic                  mem_ready
);

  localparam int WOFF_W = woff_w(WORDS_PER_LINE);
  localparam int IDX_W  = idx_w(NUM_SETS);
  localparam int TAG_W  = tag_w(ADDR_WIDTH, WORDS_PER_LINE, NUM_SETS);
  localparam int WAY_W  = $clog2(NUM_WAYS);
  localparam int CNT_W  = (WOFF_W > 0) ? WOFF_W : 1;
  localparam logic [CNT_W-1:0] LAST_WORD = CNT_W'(WORDS_PER_LINE - 1);

  logic                  r_valid [NUM_SETS][NUM_WAYS];
  logic                  r_dirty [NUM_SETS][NUM_WAYS];
  logic [TAG_W-1:0]      r_tag   [NUM_SETS][NUM_WAYS];
  logic [DATA_WIDTH-1:0] r_data  [NUM_SETS][NUM_WAYS][WORDS_PER_LINE];

  state_t                r_state;
  logic [CNT_W-1:0]      r_cnt;
  logic [WAY_W-1:0]      r_vic_way;
  logic [IDX_W-1:0]      r_idx;
  logic [TAG_W-1:0]      r_miss_tag, r_vic_tag;
  logic                  r_mem_req, r_mem_we;
  logic [ADDR_WIDTH-1:0] r_mem_addr;
  logic [DATA_WIDTH-1:0] r_mem_wdata;

  logic [CNT_W-1:0] w_word, w_cnt_nxt;
  logic [IDX_W-1:0] w_idx;
  logic [TAG_W-1:0] w_tag;
  logic [WAY_W-1:0] w_hit_way, w_vic_way;
  logic [WAY_W-1:0] w_lru_victim [NUM_SETS];
  logic w_hit, w_req, w_idle, w_miss, w_touch, w_store_hit, w_vic_wb, w_fill_beat, w_last;

  function automatic logic [ADDR_WIDTH-1:0] mk_addr(input logic [TAG_W-1:0] tag,
                                                    input logic [IDX_W-1:0] idx,
                                                    input logic [CNT_W-1:0] word);
    return (ADDR_WIDTH'(tag)  << (IDX_W + WOFF_W + BYTE_OFF_W)) |
           (ADDR_WIDTH'(idx)  << (WOFF_W + BYTE_OFF_W)) |
           (ADDR_WIDTH'(word) << BYTE_OFF_W) | ADDR_WIDTH'(BYTE_OFF);
  endfunction

  assign w_word = CNT_W'(cpu_addr >> BYTE_OFF_W) & LAST_WORD;
  assign w_idx  = IDX_W'(cpu_addr >> (BYTE_OFF_W + WOFF_W));
  assign w_tag  = TAG_W'(cpu_addr >> (BYTE_OFF_W + WOFF_W + IDX_W));

  // Descending scans let the lowest matching / lowest invalid way win.
  always_comb begin
    w_hit     = 1'b0;
    w_hit_way = '0;
    w_vic_way = w_lru_victim[w_idx];
    for (int w = NUM_WAYS - 1; w >= 0; w--) begin
      if (r_valid[w_idx][w] && (r_tag[w_idx][w] == w_tag)) begin
        w_hit     = 1'b1;
        w_hit_way = WAY_W'(w);
      end
      if (!r_valid[w_idx][w]) w_vic_way = WAY_W'(w);
    end
  end

  assign w_req       = cpu_re | cpu_we;
  assign w_idle      = (r_state == IDLE);
  assign w_miss      = w_idle && w_req && !w_hit;
  assign w_touch     = w_idle && w_req && w_hit;
  assign w_store_hit = w_touch && cpu_we;
  assign w_vic_wb    = r_valid[w_idx][w_vic_way] && r_dirty[w_idx][w_vic_way];
  assign w_fill_beat = (r_state == REFILL) && mem_ready;
  assign w_last      = (r_cnt == LAST_WORD);
  assign w_cnt_nxt   = r_cnt + 1'b1;

  for (genvar s = 0; s < NUM_SETS; s++) begin : g_lru
    cache_lru_set #(.NUM_WAYS(NUM_WAYS)) u_lru (
      .clk        (clk),
      .rst        (rst),
      .touch_en   (w_touch && (w_idx == IDX_W'(s))),
      .touch_way  (w_hit_way),
      .victim_way (w_lru_victim[s])
    );
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_vic_way   <= '0;
      r_idx       <= '0;
      r_miss_tag  <= '0;
      r_vic_tag   <= '0;
      r_mem_req   <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
    end else begin
      case (r_state)
        IDLE: if (w_miss) begin
          r_cnt      <= '0;
          r_vic_way  <= w_vic_way;
          r_idx      <= w_idx;
          r_miss_tag <= w_tag;
          r_vic_tag  <= r_tag[w_idx][w_vic_way];
          r_mem_req  <= 1'b1;
          if (w_vic_wb) begin
            r_state     <= WB;
            r_mem_we    <= 1'b1;
            r_mem_addr  <= mk_addr(r_tag[w_idx][w_vic_way], w_idx, '0);
            r_mem_wdata <= r_data[w_idx][w_vic_way][0];
          end else begin
            r_state    <= REFILL;
            r_mem_we   <= 1'b0;
            r_mem_addr <= mk_addr(w_tag, w_idx, '0);
          end
        end
        WB: if (mem_ready) begin
          if (w_last) begin
            r_state     <= REFILL;
            r_cnt       <= '0;
            r_mem_we    <= 1'b0;
            r_mem_wdata <= '0;
            r_mem_addr  <= mk_addr(r_miss_tag, r_idx, '0);
          end else begin
            r_cnt       <= w_cnt_nxt;
            r_mem_addr  <= mk_addr(r_vic_tag, r_idx, w_cnt_nxt);
            r_mem_wdata <= r_data[r_idx][r_vic_way][w_cnt_nxt];
          end
        end
        REFILL: if (mem_ready) begin
          if (w_last) begin
            r_state    <= IDLE;
            r_cnt      <= '0;
            r_mem_req  <= 1'b0;
            r_mem_addr <= '0;
          end else begin
            r_cnt      <= w_cnt_nxt;
            r_mem_addr <= mk_addr(r_miss_tag, r_idx, w_cnt_nxt);
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int s = 0; s < NUM_SETS; s++) begin
        for (int w = 0; w < NUM_WAYS; w++) begin
          r_valid[s][w] <= 1'b0;
          r_dirty[s][w] <= 1'b0;
        end
      end
    end else begin
      if (w_store_hit) r_dirty[w_idx][w_hit_way] <= 1'b1;
      if (w_fill_beat && w_last) begin
        r_valid[r_idx][r_vic_way] <= 1'b1;
        r_dirty[r_idx][r_vic_way] <= 1'b0;
      end
    end
  end

  // NOTE: data and tag arrays carry no reset; the valid bits alone decide whether their contents count.
  always_ff @(posedge clk) begin
    if (w_store_hit) r_data[w_idx][w_hit_way][w_word] <= cpu_wdata;
    if (w_fill_beat) begin
      r_data[r_idx][r_vic_way][r_cnt] <= mem_rdata;
      if (w_last) r_tag[r_idx][r_vic_way] <= r_miss_tag;
    end
  end

  assign cpu_rdata = w_hit ? r_data[w_idx][w_hit_way][w_word] : '0;
  assign stall     = !w_idle || w_miss;
  assign mem_req   = r_mem_req;
  assign mem_we    = r_mem_we;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;

endmodule

// File: tb/tb_nway_wb_cache.sv
// Bench for nway_wb_cache: a default 2-way instance and a 4-way instance, each with a word memory model.
// Expected memory beats are queued as stimulus is issued and matched as the DUT performs them.
module tb_nway_wb_cache;

  typedef struct packed {
    logic        d;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
  } beat_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        cpu_re [2], cpu_we [2], stall [2], mem_req [2], mem_we [2], mem_ready [2];
  logic [31:0] cpu_addr [2], cpu_wdata [2], cpu_rdata [2];
  logic [31:0] mem_addr [2], mem_wdata [2], mem_rdata [2];

  beat_t       exp_q [$];
  logic [31:0] mem_store [logic [32:0]];
  int          checks = 0;
  int          errors = 0;

  always #5 clk = ~clk;

  nway_wb_cache dut (
    .clk(clk), .rst(rst), .cpu_re(cpu_re[0]), .cpu_we(cpu_we[0]), .cpu_addr(cpu_addr[0]),
    .cpu_wdata(cpu_wdata[0]), .cpu_rdata(cpu_rdata[0]), .stall(stall[0]), .mem_req(mem_req[0]),
    .mem_we(mem_we[0]), .mem_addr(mem_addr[0]), .mem_wdata(mem_wdata[0]),
    .mem_rdata(mem_rdata[0]), .mem_ready(mem_ready[0])
  );

  nway_wb_cache #(.NUM_WAYS(4)) dut4 (
    .clk(clk), .rst(rst), .cpu_re(cpu_re[1]), .cpu_we(cpu_we[1]), .cpu_addr(cpu_addr[1]),
    .cpu_wdata(cpu_wdata[1]), .cpu_rdata(cpu_rdata[1]), .stall(stall[1]), .mem_req(mem_req[1]),
    .mem_we(mem_we[1]), .mem_addr(mem_addr[1]), .mem_wdata(mem_wdata[1]),
    .mem_rdata(mem_rdata[1]), .mem_ready(mem_ready[1])
  );

  // Unwritten memory holds 0xA0 + word number counted from 0x40.
  function automatic logic [31:0] mem_init(input logic [31:0] a);
    return 32'hA0 + ((a - 32'h40) >> 2);
  endfunction

  // Memory model and scoreboard: sampled mid-cycle, while mem_* and mem_ready are stable.
  always begin
    logic [32:0] key;
    beat_t       e;
    @(negedge clk);
    #2;
    for (int d = 0; d < 2; d++) begin
      key = {1'(d), mem_addr[d]};
      mem_rdata[d] = mem_store.exists(key) ? mem_store[key] : mem_init(mem_addr[d]);
      if (mem_req[d] === 1'b1 && mem_ready[d] === 1'b1) begin
        if (mem_we[d] === 1'b1) mem_store[key] = mem_wdata[d];
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_beat: dut%0d we=%0b addr=%h wdata=%h, none expected",
                   d, mem_we[d], mem_addr[d], mem_wdata[d]);
        end else begin
          e = exp_q.pop_front();
          if (e.d !== 1'(d) || e.we !== mem_we[d] || e.addr !== mem_addr[d] ||
              (e.we && e.wdata !== mem_wdata[d])) begin
            errors++;
            $display("FAIL beat: got dut%0d we=%0b addr=%h wdata=%h, expected dut%0d we=%0b addr=%h wdata=%h",
                     d, mem_we[d], mem_addr[d], mem_wdata[d], e.d, e.we, e.addr, e.wdata);
          end
        end
      end
    end
  end

  task automatic push_beat(input int d, input logic we, input logic [31:0] addr, input logic [31:0] wdata);
    exp_q.push_back('{1'(d), we, addr, wdata});
  endtask

  task automatic push_refill(input int d, input logic [31:0] base);
    for (int i = 0; i < 4; i++) push_beat(d, 1'b0, base + 32'(4 * i), 32'h0);
  endtask

  // Issues one request, holds it through the stall, returns the stalled cycle count and load data.
  task automatic access(input int d, input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                        output int stalls, output logic [31:0] rdata);
    @(negedge clk);
    cpu_re[d] = !we; cpu_we[d] = we; cpu_addr[d] = addr; cpu_wdata[d] = wdata;
    #1;
    stalls = 0;
    while (stall[d] !== 1'b0 && stalls < 200) begin
      @(negedge clk);
      #1;
      stalls++;
    end
    rdata = cpu_rdata[d];
    if (stalls >= 200) begin
      errors++;
      $display("FAIL timeout: dut%0d addr=%h still stalled after %0d cycles", d, addr, stalls);
    end
    @(posedge clk);
    #1;
    cpu_re[d] = 1'b0; cpu_we[d] = 1'b0;
  endtask

  task automatic test_reset();
    for (int d = 0; d < 2; d++) begin
      checks++;
      if ({stall[d], mem_req[d], mem_we[d]} !== 3'b000) begin
        errors++;
        $display("FAIL reset_ctrl: dut%0d stall/req/we=%b, expected 000", d, {stall[d], mem_req[d], mem_we[d]});
      end
      checks++;
      if ({mem_addr[d], mem_wdata[d], cpu_rdata[d]} !== 96'h0) begin
        errors++;
        $display("FAIL reset_data: dut%0d mem_addr=%h mem_wdata=%h cpu_rdata=%h, expected all 0",
                 d, mem_addr[d], mem_wdata[d], cpu_rdata[d]);
      end
    end
  endtask

  task automatic test_refill_load();
    int st; logic [31:0] rd;
    push_refill(0, 32'h40);
    access(0, 1'b0, 32'h40, 32'h0, st, rd);
    checks++; if (st !== 5) begin errors++; $display("FAIL refill_stalls: got %0d, expected 5", st); end
    checks++; if (rd !== 32'hA0) begin errors++; $display("FAIL refill_rdata: got %h, expected 000000a0", rd); end
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL refill_beats: %0d beats missing, expected 0", exp_q.size()); end
  endtask

  task automatic test_load_hit();
    int st; logic [31:0] rd;
    access(0, 1'b0, 32'h48, 32'h0, st, rd);
    checks++; if (st !== 0) begin errors++; $display("FAIL hit_stalls: got %0d, expected 0", st); end
    checks++; if (rd !== 32'hA2) begin errors++; $display("FAIL hit_rdata: got %h, expected 000000a2", rd); end
  endtask

  task automatic test_dirty_evict();
    int st; logic [31:0] rd;
    access(0, 1'b1, 32'h40, 32'hDEAD_BEEF, st, rd);
    checks++; if (st !== 0) begin errors++; $display("FAIL store_hit_stalls: got %0d, expected 0", st); end
    push_refill(0, 32'h140);
    access(0, 1'b0, 32'h140, 32'h0, st, rd);
    checks++; if (rd !== mem_init(32'h140)) begin errors++; $display("FAIL way1_rdata: got %h, expected %h", rd, mem_init(32'h140)); end
    push_beat(0, 1'b1, 32'h40, 32'hDEAD_BEEF);
    for (int i = 1; i < 4; i++) push_beat(0, 1'b1, 32'h40 + 32'(4 * i), 32'hA0 + 32'(i));
    push_refill(0, 32'h240);
    access(0, 1'b0, 32'h240, 32'h0, st, rd);
    checks++; if (st !== 9) begin errors++; $display("FAIL wb_stalls: got %0d, expected 9", st); end
    checks++; if (rd !== mem_init(32'h240)) begin errors++; $display("FAIL wb_rdata: got %h, expected %h", rd, mem_init(32'h240)); end
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL wb_beats: %0d beats missing, expected 0", exp_q.size()); end
    push_refill(0, 32'h40);
    access(0, 1'b0, 32'h40, 32'h0, st, rd);
    checks++; if (rd !== 32'hDEAD_BEEF) begin errors++; $display("FAIL reload_rdata: got %h, expected deadbeef", rd); end
  endtask

  task automatic test_clean_evict();
    int st; logic [31:0] rd;
    push_refill(0, 32'h50);
    access(0, 1'b0, 32'h50, 32'h0, st, rd);
    push_refill(0, 32'h150);
    access(0, 1'b0, 32'h150, 32'h0, st, rd);
    push_refill(0, 32'h250);
    access(0, 1'b0, 32'h250, 32'h0, st, rd);
    checks++; if (st !== 5) begin errors++; $display("FAIL clean_stalls: got %0d, expected 5", st); end
    checks++; if (rd !== mem_init(32'h250)) begin errors++; $display("FAIL clean_rdata: got %h, expected %h", rd, mem_init(32'h250)); end
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL clean_beats: %0d beats missing, expected 0", exp_q.size()); end
  endtask

  task automatic test_lru4();
    int st; logic [31:0] rd;
    logic [31:0] t [5];
    for (int k = 0; k < 5; k++) t[k] = (32'(k + 1) << 6) | 32'h20;
    for (int k = 0; k < 4; k++) begin
      push_refill(1, t[k]);
      access(1, 1'b0, t[k], 32'h0, st, rd);
      checks++; if (rd !== mem_init(t[k])) begin errors++; $display("FAIL lru_fill_rdata: T%0d got %h, expected %h", k, rd, mem_init(t[k])); end
    end
    access(1, 1'b0, t[0], 32'h0, st, rd);
    checks++; if (st !== 0) begin errors++; $display("FAIL lru_t0_hit: got %0d stalls, expected 0", st); end
    push_refill(1, t[4]);
    access(1, 1'b0, t[4], 32'h0, st, rd);
    checks++; if (st !== 5) begin errors++; $display("FAIL lru_t4_miss: got %0d stalls, expected 5", st); end
    for (int k = 0; k < 4; k++) begin
      if (k != 1) begin
        access(1, 1'b0, t[k], 32'h0, st, rd);
        checks++; if (st !== 0) begin errors++; $display("FAIL lru_survivor: T%0d got %0d stalls, expected 0", k, st); end
      end
    end
    push_refill(1, t[1]);
    access(1, 1'b0, t[1], 32'h0, st, rd);
    checks++; if (st !== 5) begin errors++; $display("FAIL lru_victim_t1: got %0d stalls, expected 5", st); end
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL lru_beats: %0d beats missing, expected 0", exp_q.size()); end
  endtask

  task automatic test_ready_stall_reset();
    int st; logic [31:0] rd;
    @(negedge clk);
    mem_ready[0] = 1'b0; cpu_re[0] = 1'b1; cpu_we[0] = 1'b0; cpu_addr[0] = 32'h70;
    @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      #1;
      checks++;
      if (mem_req[0] !== 1'b1 || stall[0] !== 1'b1 || mem_addr[0] !== 32'h70) begin
        errors++;
        $display("FAIL ready_hold: cycle %0d req=%b stall=%b addr=%h, expected 1 1 00000070",
                 i, mem_req[0], stall[0], mem_addr[0]);
      end
    end
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (mem_req[0] !== 1'b0 || mem_we[0] !== 1'b0) begin
      errors++;
      $display("FAIL abort_req: req=%b we=%b, expected 0 0", mem_req[0], mem_we[0]);
    end
    @(negedge clk);
    rst = 1'b0; cpu_re[0] = 1'b0; mem_ready[0] = 1'b1;
    push_refill(0, 32'h70);
    access(0, 1'b0, 32'h70, 32'h0, st, rd);
    checks++; if (st !== 5) begin errors++; $display("FAIL abort_remiss: got %0d stalls, expected 5", st); end
    checks++; if (rd !== mem_init(32'h70)) begin errors++; $display("FAIL abort_rdata: got %h, expected %h", rd, mem_init(32'h70)); end
    push_refill(0, 32'h40);
    access(0, 1'b0, 32'h40, 32'h0, st, rd);
    checks++; if (st !== 5) begin errors++; $display("FAIL invalidated: got %0d stalls, expected 5", st); end
    checks++; if (rd !== 32'hDEAD_BEEF) begin errors++; $display("FAIL wb_memory: got %h, expected deadbeef", rd); end
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL abort_beats: %0d beats missing, expected 0", exp_q.size()); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1;
    for (int d = 0; d < 2; d++) begin
      cpu_re[d] = 1'b0; cpu_we[d] = 1'b0; cpu_addr[d] = '0; cpu_wdata[d] = '0; mem_ready[d] = 1'b1;
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    test_reset();
    test_refill_load();
    test_load_hit();
    test_dirty_evict();
    test_clean_evict();
    test_lru4();
    test_ready_stall_reset();
    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
